game_flow_ctrl: RTL and testbench

- Top-level play-state sequencer for the song timer: turns debounced start/pause/stop buttons into the timer's pause and reset controls.
- Runs a pre-song countdown, detects song end against a song-length input and reports game state to the display and scoring logic.
- Sits between the button debouncers and the 10 ms song timer. The timer's song_time feeds back into this block.

---
 rtl/gflow_pkg.sv | 23 ++
 rtl/countdown_timer.sv | 55 +++++
 rtl/game_flow_ctrl.sv | 110 +++++++++++
 tb/tb_game_flow_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gflow_pkg.sv
// Shared encodings and constants for the game flow sequencer and its countdown timer.
package gflow_pkg;

   localparam int TICK_CYCLES_DEFAULT = 1_000_000;
   localparam int SONG_TIME_W         = 16;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_COUNTDOWN = 3'd1;
   localparam logic [2:0] ST_PLAYING   = 3'd2;
   localparam logic [2:0] ST_PAUSED    = 3'd3;
   localparam logic [2:0] ST_FINISHED  = 3'd4;
   localparam logic [2:0] ST_RESUME    = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_COUNTDOWN = ST_COUNTDOWN,
      S_PLAYING   = ST_PLAYING,
      S_PAUSED    = ST_PAUSED,
      S_FINISHED  = ST_FINISHED,
      S_RESUME    = ST_RESUME
   } gstate_e;

endpackage

// File: rtl/countdown_timer.sv
// Seconds countdown built from a cycle prescaler and a tick counter; reloads on load,
// clears when run drops, and flags done on the cycle secs_left would step from 1 to 0.
module countdown_timer
   import gflow_pkg::*;
#(
   parameter int CYCLES_PER_TICK = TICK_CYCLES_DEFAULT,
   parameter int TICKS_PER_SEC   = 100,
   parameter int COUNT_SECS      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   output logic [1:0] secs_left,
   output logic       done
);

   localparam int CW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   logic [CW-1:0] cycle_cnt;
   logic [TW-1:0] sec_tick_cnt;
   logic          tick_wrap;
   logic          sec_wrap;

   assign tick_wrap = (cycle_cnt == CW'(CYCLES_PER_TICK - 1));
   assign sec_wrap  = tick_wrap && (sec_tick_cnt == TW'(TICKS_PER_SEC - 1));
   // secs_left is zero whenever idle, so done needs no separate enable
   assign done      = sec_wrap && (secs_left == 2'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt    <= '0;
         sec_tick_cnt <= '0;
         secs_left    <= 2'd0;
      end else if (load) begin
         cycle_cnt    <= '0;
         sec_tick_cnt <= '0;
         secs_left    <= 2'(COUNT_SECS);
      end else if (!run || done) begin
         cycle_cnt    <= '0;
         sec_tick_cnt <= '0;
         secs_left    <= 2'd0;
      end else begin
         cycle_cnt <= tick_wrap ? '0 : cycle_cnt + 1'b1;
         if (tick_wrap) begin
            sec_tick_cnt <= sec_wrap ? '0 : sec_tick_cnt + 1'b1;
         end
         if (sec_wrap) begin
            secs_left <= secs_left - 2'd1;
         end
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Play-state sequencer driving the song timer's pause/reset from start/pause/stop buttons.
// Optional RESUME_COUNTDOWN_EN inserts a countdown between PAUSED and PLAYING.
module game_flow_ctrl
   import gflow_pkg::*;
#(
   parameter int CYCLES_PER_TICK = TICK_CYCLES_DEFAULT,
   parameter int TICKS_PER_SEC   = 100,
   parameter int COUNT_SECS      = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_start,
   input  logic                   btn_pause,
   input  logic                   btn_stop,
   input  logic [SONG_TIME_W-1:0] song_time,
   input  logic [SONG_TIME_W-1:0] song_length,
   output logic                   timer_pause,
   output logic                   timer_reset,
   output logic [2:0]             state,
   output logic [1:0]             countdown_val,
   output logic                   song_done
);

   gstate_e    state_q, state_d;
   logic [2:0] btn_prev;
   logic [2:0] press_q;
   logic       press_start, press_pause, press_stop;
   logic       cd_load, cd_run, cd_done;
   logic       song_end;

   // History starts at 1 so a button held through reset is not seen as a press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev <= 3'b111;
         press_q  <= 3'b000;
      end else begin
         btn_prev <= {btn_stop, btn_pause, btn_start};
         press_q  <= {btn_stop, btn_pause, btn_start} & ~btn_prev;
      end
   end

   assign press_start = press_q[0];
   assign press_pause = press_q[1];
   assign press_stop  = press_q[2];
   assign song_end    = (song_time >= song_length);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (press_stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      if (press_start) state_d = S_COUNTDOWN;
            S_COUNTDOWN: if (cd_done) state_d = S_PLAYING;
            // Song end outranks a simultaneous pause press
            S_PLAYING: begin
               if (song_end)         state_d = S_FINISHED;
               else if (press_pause) state_d = S_PAUSED;
            end
`ifdef RESUME_COUNTDOWN_EN
            S_PAUSED:    if (press_pause) state_d = S_RESUME;
            S_RESUME: begin
               if (cd_done)          state_d = S_PLAYING;
               else if (press_pause) state_d = S_PAUSED;
            end
`else
            S_PAUSED:    if (press_pause) state_d = S_PLAYING;
`endif
            S_FINISHED:  if (press_start) state_d = S_COUNTDOWN;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   assign cd_run  = (state_d == S_COUNTDOWN) || (state_d == S_RESUME);
   assign cd_load = cd_run && (state_d != state_q);

   countdown_timer #(
      .CYCLES_PER_TICK(CYCLES_PER_TICK),
      .TICKS_PER_SEC  (TICKS_PER_SEC),
      .COUNT_SECS     (COUNT_SECS)
   ) u_countdown (
      .clk      (clk),
      .rst      (reset),
      .load     (cd_load),
      .run      (cd_run),
      .secs_left(countdown_val),
      .done     (cd_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_reset <= 1'b1;
         timer_pause <= 1'b1;
         song_done   <= 1'b0;
      end else begin
         timer_reset <= (state_d == S_IDLE) || (state_d == S_COUNTDOWN);
         timer_pause <= (state_d != S_PLAYING);
         song_done   <= (state_q == S_PLAYING) && (state_d == S_FINISHED);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl against a cycle-level behavioural model.
module tb_game_flow_ctrl;

   localparam int CPT      = 4;
   localparam int TPS      = 2;
   localparam int CS       = 3;
   localparam int CD_SEC   = CPT * TPS;
   localparam int CD_TOTAL = CS * CD_SEC;
`ifdef RESUME_COUNTDOWN_EN
   localparam bit RESUME_ON = 1'b1;
`else
   localparam bit RESUME_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_start, btn_pause, btn_stop;
   logic [15:0] song_time, song_length;
   logic        timer_pause, timer_reset, song_done;
   logic [2:0]  state;
   logic [1:0]  countdown_val;

   int vectors     = 0;
   int miscompares = 0;

   int         m_state;
   int         m_elapsed;
   logic       m_done;
   logic [2:0] m_prev;
   logic [2:0] m_pend;
   bit         auto_time = 1'b0;

   wire [7:0] dut_vec = {state, timer_reset, timer_pause, countdown_val, song_done};

   game_flow_ctrl #(
      .CYCLES_PER_TICK(CPT),
      .TICKS_PER_SEC  (TPS),
      .COUNT_SECS     (CS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_start    (btn_start),
      .btn_pause    (btn_pause),
      .btn_stop     (btn_stop),
      .song_time    (song_time),
      .song_length  (song_length),
      .timer_pause  (timer_pause),
      .timer_reset  (timer_reset),
      .state        (state),
      .countdown_val(countdown_val),
      .song_done    (song_done)
   );

   always #5 clk = ~clk;

   // Reference model: states 0..5 as in the interface, countdown as elapsed cycles
   function automatic void model_reset();
      m_state   = 0;
      m_elapsed = 0;
      m_done    = 1'b0;
      m_prev    = 3'b111;
      m_pend    = 3'b000;
   endfunction

   function automatic void model_step();
      int nxt;
      logic [2:0] b;
      b   = {btn_stop, btn_pause, btn_start};
      nxt = m_state;
      if (m_pend[2] && m_state != 0) nxt = 0;
      else begin
         case (m_state)
            0: if (m_pend[0]) nxt = 1;
            1: if (m_elapsed == CD_TOTAL - 1) nxt = 2;
            2: if (song_time >= song_length) nxt = 4;
               else if (m_pend[1]) nxt = 3;
            3: if (m_pend[1]) nxt = RESUME_ON ? 5 : 2;
            4: if (m_pend[0]) nxt = 1;
            5: if (m_elapsed == CD_TOTAL - 1) nxt = 2;
               else if (m_pend[1]) nxt = 3;
            default: nxt = 0;
         endcase
      end
      m_done = (m_state == 2) && (nxt == 4);
      if (nxt == 1 || nxt == 5) m_elapsed = (nxt == m_state) ? m_elapsed + 1 : 0;
      else m_elapsed = 0;
      m_pend  = b & ~m_prev;
      m_prev  = b;
      m_state = nxt;
   endfunction

   function automatic logic [7:0] exp_vec();
      logic       tr, tp;
      logic [1:0] cv;
      tr = (m_state == 0) || (m_state == 1);
      tp = (m_state != 2);
      cv = (m_state == 1 || m_state == 5) ? 2'(CS - m_elapsed / CD_SEC) : 2'd0;
      return {3'(m_state), tr, tp, cv, m_done};
   endfunction

   // Advance one clock; optionally emulate the song timer from the expected controls
   task automatic tick();
      logic [7:0] ev;
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (auto_time) begin
         ev = exp_vec();
         if (ev[4]) song_time = 16'd0;
         else if (!ev[3] && song_time != 16'hFFFF) song_time = song_time + 16'd1;
      end
   endtask

   task automatic go_playing();
      song_length = 16'hFFFF;
      song_time   = 16'd0;
      btn_start = 1'b0; btn_pause = 1'b0; btn_stop = 1'b1;
      tick();
      btn_stop = 1'b0;
      tick();
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      repeat (CD_TOTAL + 3) tick();
   endtask

   task automatic test_reset();
      btn_start = 1'b1; btn_pause = 1'b0; btn_stop = 1'b0;
      song_time = 16'd0; song_length = 16'd100;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      model_reset();
      vectors++;
      if (dut_vec !== exp_vec()) begin
         miscompares++;
         $display("FAIL reset_values: got %h expected %h", dut_vec, exp_vec());
      end
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         btn_start = (c < 4) || (c >= 5);
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL start_held_reset c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
      btn_start = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1 model_reset();
      vectors++;
      if (dut_vec !== exp_vec()) begin
         miscompares++;
         $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_countdown();
      btn_pause = 1'b0; btn_stop = 1'b0; song_length = 16'd100; song_time = 16'd0;
      for (int c = 0; c < CD_TOTAL + 8; c++) begin
         btn_start = (c == 0);
         btn_pause = (c == 5);
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL countdown c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_song_end();
      go_playing();
      song_length = 16'd5;
      for (int t = 0; t < 10; t++) begin
         song_time = (t <= 5) ? 16'(t) : 16'd5;
         btn_start = (t == 8);
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL song_end t=%0d: got %h expected %h", t, dut_vec, exp_vec());
         end
      end
      btn_start = 1'b0;
   endtask

   task automatic test_pause();
      go_playing();
      song_time = 16'd7;
      for (int c = 0; c < CD_TOTAL + 12; c++) begin
         btn_pause = (c == 0) || (c == 5);
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL pause_resume c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_pause_at_end();
      go_playing();
      song_length = 16'd10;
      song_time   = 16'd9;
      for (int c = 0; c < 5; c++) begin
         btn_pause = (c == 0);
         if (c == 1) song_time = 16'd10;
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL pause_at_end c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_stop();
      for (int s = 0; s < 3; s++) begin
         go_playing();
         if (s == 0) begin
            btn_stop = 1'b1; tick(); btn_stop = 1'b0; tick();
            btn_start = 1'b1; tick(); btn_start = 1'b0;
            repeat (10) tick();
         end else if (s == 1) begin
            btn_pause = 1'b1; tick(); btn_pause = 1'b0;
            repeat (3) tick();
         end else begin
            song_length = 16'd0;
            repeat (3) tick();
         end
         for (int c = 0; c < 4; c++) begin
            btn_stop = (c == 0);
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
               miscompares++;
               $display("FAIL stop s=%0d c=%0d: got %h expected %h", s, c, dut_vec, exp_vec());
            end
         end
      end
   endtask

   task automatic test_len_zero();
      song_length = 16'd0; song_time = 16'd0;
      for (int c = 0; c < CD_TOTAL + 8; c++) begin
         btn_start = (c == 1);
         btn_stop  = (c == 1);
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL len_zero c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
      btn_start = 1'b0; btn_stop = 1'b0;
   endtask

   task automatic test_random();
      auto_time   = 1'b1;
      song_length = 16'd30;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 11) == 0) btn_start = ~btn_start;
         if ($urandom_range(0, 9) == 0)  btn_pause = ~btn_pause;
         if ($urandom_range(0, 39) == 0) btn_stop  = ~btn_stop;
         if ($urandom_range(0, 99) == 0) song_length = 16'($urandom_range(0, 60));
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b1;
            #1 model_reset();
            vectors++;
            if (dut_vec !== exp_vec()) begin
               miscompares++;
               $display("FAIL random_reset c=%0d: got %h expected %h", c, dut_vec, exp_vec());
            end
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
         end
         tick();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c=%0d: got %h expected %h", c, dut_vec, exp_vec());
         end
      end
      auto_time = 1'b0;
   endtask

   initial begin
      test_reset();
      test_countdown();
      test_song_end();
      test_pause();
      test_pause_at_end();
      test_stop();
      test_len_zero();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
